// File: rtl/block_mem.sv
// block_mem: multi-cycle block memory model.
//
// Serves block reads and block writes of WORDS_PER_BLOCK aligned words. Each
// request finishes LATENCY cycles after it is accepted.
//
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset (memory contents are kept)
//   req      - request, sampled only while ready=1
//   we       - 1 = block write, 0 = block read, sampled with req
//   address  - byte address; only the word-index bits are used
//   wdata    - write block, word 0 in the LSBs
//   ready    - a request can be accepted at the next rising edge
//   rdata    - last block read, word 0 in the LSBs
//   valid    - one-cycle completion pulse for reads and writes
module block_mem #(
    parameter int    WORD_WIDTH      = 32,
    parameter int    WORDS_PER_BLOCK = 4,
    parameter int    DEPTH_WORDS     = 256,
    parameter int    LATENCY         = 10,
    parameter string INIT_FILE       = ""
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  req,
    input  logic                                  we,
    input  logic [31:0]                           address,
    input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] wdata,
    output logic                                  ready,
    output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] rdata,
    output logic                                  valid
);

    localparam int BLOCK_W = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int CNT_W   = $clog2(LATENCY + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        counter;
    logic [IDX_W-1:0]        base_q;
    logic                    we_q;
    logic [BLOCK_W-1:0]      wdata_q;
    logic [WORD_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic [IDX_W-1:0]        word_idx;
    logic [IDX_W-1:0]        req_base;
    logic                    complete;
    logic [BLOCK_W-1:0]      rd_block;
    logic                    unused_addr;

    // Upper address bits wrap the index modulo the depth; the byte offset is
    // ignored. Clearing the low bits of the word index gives the block base.
    assign word_idx    = address[IDX_W+1:2];
    assign req_base    = word_idx & ~IDX_W'(WORDS_PER_BLOCK - 1);
    assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};

    // The completion cycle also accepts a new request, so back-to-back
    // requests finish exactly LATENCY cycles apart.
    assign complete = (state == BUSY) && (counter == CNT_W'(LATENCY));
    assign ready    = (state == IDLE) || complete;

    always_comb begin
        rd_block = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            rd_block[k*WORD_WIDTH +: WORD_WIDTH] = mem[base_q + IDX_W'(k)];
        end
    end

    // Control FSM. A request accepted at the completion edge keeps the FSM in
    // BUSY; the finishing access still uses the previously captured values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= '0;
            valid   <= 1'b0;
            rdata   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            valid <= 1'b0;
            if (complete) begin
                valid <= 1'b1;
                if (!we_q) begin
                    rdata <= rd_block;
                end
            end
            if (req && ready) begin
                state   <= BUSY;
                counter <= CNT_W'(1);
                base_q  <= req_base;
                we_q    <= we;
                wdata_q <= wdata;
            end else if (complete) begin
                state   <= IDLE;
                counter <= '0;
            end else if (state == BUSY) begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

    // Storage array has no reset; a reset clears the FSM first, so an aborted
    // write never reaches this block.
    always_ff @(posedge clock) begin
        if (complete && we_q) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                mem[base_q + IDX_W'(k)] <= wdata_q[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_block_mem.sv
module tb_block_mem;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         req, we;
    logic [31:0]  address;
    logic [127:0] wdata;
    logic         ready, valid;
    logic [127:0] rdata;

    logic         sreq, swe;
    logic [31:0]  saddr;
    logic [15:0]  swdata;
    logic         sready, svalid;
    logic [15:0]  srdata;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    block_mem dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .address(address),
        .wdata(wdata), .ready(ready), .rdata(rdata), .valid(valid)
    );

    block_mem #(.WORD_WIDTH(16), .WORDS_PER_BLOCK(1), .DEPTH_WORDS(64), .LATENCY(1)) sdut (
        .clock(clock), .reset_n(reset_n), .req(sreq), .we(swe), .address(saddr),
        .wdata(swdata), .ready(sready), .rdata(srdata), .valid(svalid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the default instance: entries pushed at acceptance,
    // resolved against a reference memory at completion.
    typedef struct {
        logic         w;
        int           base;
        logic [127:0] d;
        int           acc;
    } pend_t;

    pend_t        q[$];
    logic [31:0]  ref_mem [256];
    logic [127:0] last_rd = '0;

    always @(negedge clock) begin : mon_main
        pend_t        e;
        logic [127:0] x;
        int           wi;
        if (!reset_n) begin
            q.delete();
            last_rd = '0;
        end else begin
            if (valid) begin
                if (q.size() == 0) begin
                    checkOutput("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("latency", cycle - e.acc, 10);
                    if (e.w) begin
                        checkOutput("wr_rdata_hold", rdata, last_rd);
                        for (int k = 0; k < 4; k++) ref_mem[e.base + k] = e.d[k*32 +: 32];
                    end else begin
                        for (int k = 0; k < 4; k++) x[k*32 +: 32] = ref_mem[e.base + k];
                        checkOutput("rd_data", rdata, x);
                        last_rd = x;
                    end
                end
            end
            if (req && ready) begin
                wi = int'((address >> 2) & 32'hFF);
                e.w = we; e.base = wi - (wi % 4); e.d = wdata; e.acc = cycle + 1;
                q.push_back(e);
            end
        end
    end

    // Scoreboard for the single-word, latency-1 instance.
    typedef struct {
        logic        w;
        int          wi;
        logic [15:0] d;
        int          acc;
    } spend_t;

    spend_t      sq[$];
    logic [15:0] smem [64];

    always @(negedge clock) begin : mon_sweep
        spend_t e;
        if (!reset_n) begin
            sq.delete();
        end else begin
            if (svalid) begin
                if (sq.size() == 0) begin
                    checkOutput("s_spurious_valid", 1, 0);
                end else begin
                    e = sq.pop_front();
                    checkOutput("s_latency", cycle - e.acc, 1);
                    if (e.w) smem[e.wi] = e.d;
                    else     checkOutput("s_rd_data", srdata, smem[e.wi]);
                end
            end
            if (sreq && sready) begin
                e.w = swe; e.wi = int'((saddr >> 2) & 32'h3F); e.d = swdata; e.acc = cycle + 1;
                sq.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [127:0] d);
        bit ok = 0;
        req = 1'b1; we = w; address = a; wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            ok = ready;
            @(posedge clock);
            #1;
        end
        req = 1'b0;
        checkOutput("accept", ok, 1);
    endtask

    task automatic waitValid(input int bound, output bit got, output logic [127:0] rd, output int vc);
        got = 0; rd = '0; vc = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clock);
            if (valid) begin got = 1; rd = rdata; vc = cycle; end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic waitIdle();
        int i = 0;
        while (i < 60 && (q.size() != 0 || ready !== 1'b1)) begin
            @(posedge clock);
            i++;
        end
        #1;
        checkOutput("drain", (q.size() == 0) && ready, 1);
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin : main
        bit           got, ok;
        logic [127:0] rd, blk;
        int           vc, e0, nv;

        vt[0] = '{1'b0, 32'h0000_0024, '0, 128'h0000010B_0000010A_00000109_00000108};
        vt[1] = '{1'b0, 32'h0000_0404, '0, 128'h00000103_00000102_00000101_00000100};
        vt[2] = '{1'b0, 32'h0000_03FC, '0, 128'h000001FF_000001FE_000001FD_000001FC};
        vt[3] = '{1'b0, 32'hFFFF_FF00, '0, 128'h000001C3_000001C2_000001C1_000001C0};
        vt[4] = '{1'b1, 32'h0000_0060, 128'h44444444_33333333_22222222_11111111,
                  128'h000001C3_000001C2_000001C1_000001C0};
        vt[5] = '{1'b0, 32'h0000_006B, '0, 128'h44444444_33333333_22222222_11111111};

        reset_n = 1'b0; req = 1'b0; we = 1'b0; address = '0; wdata = '0;
        sreq = 1'b0; swe = 1'b0; saddr = '0; swdata = '0;
        #12;
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_rdata", rdata, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        $display("[TB] loading memory pattern mem[i]=i+0x100");
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 4; k++) blk[k*32 +: 32] = 32'(b*4 + k + 256);
            applyStimulus(1'b1, 32'(b*16), blk);
        end
        waitIdle();

        $display("[TB] default-latency read timing");
        req = 1'b1; we = 1'b0; address = 32'h24; wdata = '0;
        @(negedge clock);
        checkOutput("idle_ready", ready, 1);
        @(posedge clock); #1;
        req = 1'b0;
        e0 = cycle;
        ok = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            if (ready !== 1'b0 || valid !== 1'b0) ok = 0;
        end
        checkOutput("busy_not_ready", ok, 1);
        @(negedge clock);
        checkOutput("completion_ready", ready, 1);
        checkOutput("early_valid", valid, 0);
        @(negedge clock);
        checkOutput("valid_pulse", valid, 1);
        checkOutput("timing_rdata", rdata, 128'h0000010B_0000010A_00000109_00000108);
        checkOutput("valid_edge", cycle - e0, 10);
        @(negedge clock);
        checkOutput("valid_once", valid, 0);
        checkOutput("ready_after", ready, 1);
        @(posedge clock); #1;

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vt[i].w, vt[i].a, vt[i].d);
            waitValid(20, got, rd, vc);
            checkOutput($sformatf("vec%0d_valid", i), got, 1);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end

        $display("[TB] write then read back to back");
        applyStimulus(1'b1, 32'h40, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        e0 = cycle;
        repeat (9) @(posedge clock);
        #1;
        req = 1'b1; we = 1'b0; address = 32'h4C;
        @(negedge clock);
        checkOutput("raw_ready", ready, 1);
        @(posedge clock); #1;
        req = 1'b0;
        @(negedge clock);
        checkOutput("raw_wr_valid", valid, 1);
        checkOutput("raw_wr_rdata", rdata, vt[5].exp);
        waitValid(15, got, rd, vc);
        checkOutput("raw_rd_valid", got, 1);
        checkOutput("raw_rd_data", rd, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        checkOutput("raw_rd_edge", vc - e0, 20);

        $display("[TB] request while busy is dropped");
        applyStimulus(1'b0, 32'h30, '0);
        @(posedge clock); #1;
        req = 1'b1; we = 1'b0; address = 32'h50;
        repeat (7) @(posedge clock);
        #1;
        req = 1'b0;
        nv = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid) begin nv++; rd = rdata; end
        end
        checkOutput("drop_one_valid", nv, 1);
        checkOutput("drop_rdata", rd, 128'h0000010F_0000010E_0000010D_0000010C);
        @(posedge clock); #1;

        $display("[TB] reset during a write");
        applyStimulus(1'b1, 32'h80, {4{32'h5555_5555}});
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_rdata", rdata, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 32'h80, '0);
        waitValid(20, got, rd, vc);
        checkOutput("rst_rd_valid", got, 1);
        checkOutput("rst_rd_data", rd, 128'h00000123_00000122_00000121_00000120);

        $display("[TB] latency-1 single-word burst");
        nv = 0;
        sreq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            swe    = (i < 8);
            saddr  = (i < 8) ? 32'((8 + i) * 4) : 32'(32'h100 + (8 + i - 8) * 4 + 2);
            swdata = 16'(16'hA000 + i * 16'h11);
            @(negedge clock);
            if (svalid) nv++;
            if (i >= 1) checkOutput($sformatf("s_ready%0d", i), sready, 1);
            @(posedge clock); #1;
        end
        sreq = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (svalid) nv++;
        end
        @(negedge clock);
        checkOutput("s_valid_end", svalid, 0);
        checkOutput("s_valid_count", nv, 16);
        @(posedge clock); #1;
        checkOutput("s_drain", sq.size(), 0);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
